// File: rtl/id_stage.sv
// Decode stage: instruction decode, GPR read with EX/MEM bypass, branch resolve, ID/EX register.
// Build option ID_FORWARD_EN: defined enables EX/MEM bypass; undefined stalls on any pending producer.
module id_stage #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] IFPC,
    input  logic [31:0]       IFInsn,
    input  logic              IFEn,
    output logic [RA_W-1:0]   GprRdAddr0,
    output logic [RA_W-1:0]   GprRdAddr1,
    input  logic [DATA_W-1:0] GprRdData0,
    input  logic [DATA_W-1:0] GprRdData1,
    input  logic [RA_W-1:0]   ExDst,
    input  logic              ExWE_,
    input  logic              ExLoad,
    input  logic [DATA_W-1:0] ExFwd,
    input  logic [RA_W-1:0]   MemDst,
    input  logic              MemWE_,
    input  logic [DATA_W-1:0] MemFwd,
    output logic              BrTaken,
    output logic [ADDR_W-1:0] BrAddr,
    output logic              LdHazard,
    output logic [ADDR_W-1:0] IDPC,
    output logic              IDEn,
    output logic [3:0]        IDAluOp,
    output logic [DATA_W-1:0] IDAluIn0,
    output logic [DATA_W-1:0] IDAluIn1,
    output logic [1:0]        IDMemOp,
    output logic [DATA_W-1:0] IDMemWrData,
    output logic [RA_W-1:0]   IDDst,
    output logic              IDGprWE_,
    output logic [2:0]        IDExpCode
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned IMM_W = 16;

    localparam logic [OP_W-1:0] OP_BE   = 6'h10;
    localparam logic [OP_W-1:0] OP_BNE  = 6'h11;
    localparam logic [OP_W-1:0] OP_BSGT = 6'h12;
    localparam logic [OP_W-1:0] OP_BUGT = 6'h13;
    localparam logic [OP_W-1:0] OP_JMP  = 6'h14;
    localparam logic [OP_W-1:0] OP_CALL = 6'h15;
    localparam logic [OP_W-1:0] OP_LDW  = 6'h16;
    localparam logic [OP_W-1:0] OP_STW  = 6'h17;
    localparam logic [OP_W-1:0] OP_TRAP = 6'h18;

    localparam logic [3:0] ALU_ADDU = 4'h1;
    localparam logic [3:0] ALU_PASS = 4'h8;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_LDW  = 2'b01;
    localparam logic [1:0] MEM_STW  = 2'b10;

    localparam logic [2:0] EXP_NONE    = 3'd0;
    localparam logic [2:0] EXP_ILLEGAL = 3'd1;
    localparam logic [2:0] EXP_TRAP    = 3'd2;

    localparam logic [RA_W-1:0] LINK_REG = '1;

    logic [OP_W-1:0]   op;
    logic [RA_W-1:0]   ra;
    logic [RA_W-1:0]   rb;
    logic [RA_W-1:0]   rc;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_rel;

    assign op  = IFInsn[31:26];
    assign ra  = RA_W'(IFInsn[25:21]);
    assign rb  = RA_W'(IFInsn[20:16]);
    assign rc  = RA_W'(IFInsn[15:11]);
    assign imm = IFInsn[15:0];

    assign GprRdAddr0 = ra;
    assign GprRdAddr1 = rb;

    assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext = DATA_W'(imm);
    assign pc_inc   = IFPC + ADDR_W'(1);
    assign br_rel   = pc_inc + {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};

    // Which register sources the instruction actually reads (depends on opcode only)
    logic rd_ra;
    logic rd_rb;

    always_comb begin
        rd_ra = 1'b0;
        rd_rb = 1'b0;
        if (op < OP_BE) begin
            rd_ra = 1'b1;
            rd_rb = !op[0];
        end else begin
            case (op)
                OP_BE, OP_BNE, OP_BSGT, OP_BUGT, OP_STW: begin
                    rd_ra = 1'b1;
                    rd_rb = 1'b1;
                end
                OP_JMP, OP_CALL, OP_LDW: rd_ra = 1'b1;
                default: ;
            endcase
        end
    end

    logic ex_hit_ra;
    logic ex_hit_rb;
    logic mem_hit_ra;
    logic mem_hit_rb;

    assign ex_hit_ra  = !ExWE_  && (ExDst  == ra);
    assign ex_hit_rb  = !ExWE_  && (ExDst  == rb);
    assign mem_hit_ra = !MemWE_ && (MemDst == ra);
    assign mem_hit_rb = !MemWE_ && (MemDst == rb);

    logic [DATA_W-1:0] ra_val;
    logic [DATA_W-1:0] rb_val;

`ifdef ID_FORWARD_EN
    // Youngest producer wins; only a load in EX cannot be bypassed
    assign ra_val   = ex_hit_ra ? ExFwd : (mem_hit_ra ? MemFwd : GprRdData0);
    assign rb_val   = ex_hit_rb ? ExFwd : (mem_hit_rb ? MemFwd : GprRdData1);
    assign LdHazard = IFEn && ExLoad && ((rd_ra && ex_hit_ra) || (rd_rb && ex_hit_rb));
`else
    assign ra_val   = GprRdData0;
    assign rb_val   = GprRdData1;
    assign LdHazard = IFEn && ((rd_ra && (ex_hit_ra || mem_hit_ra)) ||
                               (rd_rb && (ex_hit_rb || mem_hit_rb)));

    logic unused_fwd;
    assign unused_fwd = ^{ExLoad, ExFwd, MemFwd};
`endif

    logic [3:0]        dec_alu_op;
    logic [DATA_W-1:0] dec_in0;
    logic [DATA_W-1:0] dec_in1;
    logic [1:0]        dec_mem_op;
    logic [RA_W-1:0]   dec_dst;
    logic              dec_we_;
    logic [2:0]        dec_exp;
    logic              br_cond;

    // Main decode: ALU ops 0x00-0x0f map to alu op = opcode[3:1]
    always_comb begin
        dec_alu_op = ALU_ADDU;
        dec_in0    = ra_val;
        dec_in1    = rb_val;
        dec_mem_op = MEM_NONE;
        dec_dst    = rc;
        dec_we_    = 1'b1;
        dec_exp    = EXP_NONE;
        br_cond    = 1'b0;
        BrAddr     = br_rel;
        if (op < OP_BE) begin
            dec_alu_op = {1'b0, op[3:1]};
            dec_we_    = 1'b0;
            if (op[0]) begin
                dec_in1 = (op[3:1] < 3'd2) ? imm_sext : imm_zext;
                dec_dst = rb;
            end
        end else begin
            case (op)
                OP_BE:   br_cond = (ra_val == rb_val);
                OP_BNE:  br_cond = (ra_val != rb_val);
                OP_BSGT: br_cond = ($signed(ra_val) > $signed(rb_val));
                OP_BUGT: br_cond = (ra_val > rb_val);
                OP_JMP: begin
                    br_cond = 1'b1;
                    BrAddr  = ra_val[DATA_W-1 -: ADDR_W];
                end
                OP_CALL: begin
                    br_cond    = 1'b1;
                    BrAddr     = ra_val[DATA_W-1 -: ADDR_W];
                    dec_alu_op = ALU_PASS;
                    dec_in0    = DATA_W'({pc_inc, 2'b00});
                    dec_dst    = LINK_REG;
                    dec_we_    = 1'b0;
                end
                OP_LDW: begin
                    dec_in1    = imm_sext;
                    dec_mem_op = MEM_LDW;
                    dec_dst    = rb;
                    dec_we_    = 1'b0;
                end
                OP_STW: begin
                    dec_in1    = imm_sext;
                    dec_mem_op = MEM_STW;
                end
                OP_TRAP: dec_exp = EXP_TRAP;
                default: dec_exp = EXP_ILLEGAL;
            endcase
        end
    end

    assign BrTaken = IFEn && !LdHazard && br_cond;

    logic take_bubble;
    logic load_en;

    assign take_bubble = Flush || (!Stall && (LdHazard || !IFEn));
    assign load_en     = !Flush && !Stall && !LdHazard && IFEn;

    // ID/EX register; a bubble only clears the control fields, data fields keep their value
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            IDPC        <= '0;
            IDEn        <= 1'b0;
            IDAluOp     <= '0;
            IDAluIn0    <= '0;
            IDAluIn1    <= '0;
            IDMemOp     <= MEM_NONE;
            IDMemWrData <= '0;
            IDDst       <= '0;
            IDGprWE_    <= 1'b1;
            IDExpCode   <= EXP_NONE;
        end else if (take_bubble) begin
            IDEn      <= 1'b0;
            IDGprWE_  <= 1'b1;
            IDMemOp   <= MEM_NONE;
            IDExpCode <= EXP_NONE;
        end else if (load_en) begin
            IDPC        <= IFPC;
            IDEn        <= 1'b1;
            IDAluOp     <= dec_alu_op;
            IDAluIn0    <= dec_in0;
            IDAluIn1    <= dec_in1;
            IDMemOp     <= dec_mem_op;
            IDMemWrData <= rb_val;
            IDDst       <= dec_dst;
            IDGprWE_    <= dec_we_;
            IDExpCode   <= dec_exp;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected ID register contents are queued per cycle and
// compared one edge later; combinational branch/hazard outputs are checked in-cycle.
module tb_id_stage;

    localparam logic [3:0] ALU_ADDS = 4'h0;
    localparam logic [3:0] ALU_ADDU = 4'h1;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_PASS = 4'h8;

    typedef struct {
        logic        en;
        logic [29:0] pc;
        logic [3:0]  op;
        logic [31:0] in0;
        logic [31:0] in1;
        logic [31:0] wd;
        logic [1:0]  mop;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  xc;
        bit          c_pc;
        bit          c_alu;
        bit          c_in1;
        bit          c_dst;
        bit          c_wd;
    } id_exp_t;

    logic        clk = 1'b0;
    logic        reset_;
    logic        Stall, Flush;
    logic [29:0] IFPC;
    logic [31:0] IFInsn;
    logic        IFEn;
    logic [4:0]  GprRdAddr0, GprRdAddr1;
    logic [31:0] GprRdData0, GprRdData1;
    logic [4:0]  ExDst;
    logic        ExWE_, ExLoad;
    logic [31:0] ExFwd;
    logic [4:0]  MemDst;
    logic        MemWE_;
    logic [31:0] MemFwd;
    logic        BrTaken;
    logic [29:0] BrAddr;
    logic        LdHazard;
    logic [29:0] IDPC;
    logic        IDEn;
    logic [3:0]  IDAluOp;
    logic [31:0] IDAluIn0, IDAluIn1;
    logic [1:0]  IDMemOp;
    logic [31:0] IDMemWrData;
    logic [4:0]  IDDst;
    logic        IDGprWE_;
    logic [2:0]  IDExpCode;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset_(reset_), .Stall(Stall), .Flush(Flush),
        .IFPC(IFPC), .IFInsn(IFInsn), .IFEn(IFEn),
        .GprRdAddr0(GprRdAddr0), .GprRdAddr1(GprRdAddr1),
        .GprRdData0(GprRdData0), .GprRdData1(GprRdData1),
        .ExDst(ExDst), .ExWE_(ExWE_), .ExLoad(ExLoad), .ExFwd(ExFwd),
        .MemDst(MemDst), .MemWE_(MemWE_), .MemFwd(MemFwd),
        .BrTaken(BrTaken), .BrAddr(BrAddr), .LdHazard(LdHazard),
        .IDPC(IDPC), .IDEn(IDEn), .IDAluOp(IDAluOp),
        .IDAluIn0(IDAluIn0), .IDAluIn1(IDAluIn1),
        .IDMemOp(IDMemOp), .IDMemWrData(IDMemWrData),
        .IDDst(IDDst), .IDGprWE_(IDGprWE_), .IDExpCode(IDExpCode)
    );

    int      n_checks = 0;
    int      n_fail   = 0;
    id_exp_t sb[$];
    id_exp_t cur;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] ra,
                                          input logic [4:0] rb, input logic [15:0] imm);
        return {op, ra, rb, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] ra,
                                          input logic [4:0] rb, input logic [4:0] rc);
        return {op, ra, rb, rc, 11'd0};
    endfunction

    function automatic id_exp_t e_bub();
        id_exp_t e;
        e = '{default: 0};
        e.we_ = 1'b1;
        return e;
    endfunction

    function automatic id_exp_t e_rst();
        id_exp_t e;
        e = e_bub();
        e.c_pc = 1; e.c_alu = 1; e.c_in1 = 1; e.c_dst = 1; e.c_wd = 1;
        return e;
    endfunction

    function automatic id_exp_t e_ctl(input logic [29:0] pc, input logic we_,
                                      input logic [1:0] mop, input logic [2:0] xc);
        id_exp_t e;
        e = e_bub();
        e.en = 1'b1; e.pc = pc; e.c_pc = 1; e.we_ = we_; e.mop = mop; e.xc = xc;
        return e;
    endfunction

    function automatic id_exp_t e_alu(input logic [29:0] pc, input logic [3:0] op,
                                      input logic [31:0] in0, input logic [31:0] in1,
                                      input logic [4:0] dst, input logic we_, input logic [1:0] mop);
        id_exp_t e;
        e = e_ctl(pc, we_, mop, 3'd0);
        e.op = op; e.in0 = in0; e.in1 = in1; e.dst = dst;
        e.c_alu = 1; e.c_in1 = 1; e.c_dst = 1;
        return e;
    endfunction

    task automatic compare_reg(input string tag, input id_exp_t e);
        check({tag, ".en"},  64'(IDEn),      64'(e.en));
        check({tag, ".we_"}, 64'(IDGprWE_),  64'(e.we_));
        check({tag, ".mop"}, 64'(IDMemOp),   64'(e.mop));
        check({tag, ".xc"},  64'(IDExpCode), 64'(e.xc));
        if (e.c_pc) check({tag, ".pc"}, 64'(IDPC), 64'(e.pc));
        if (e.c_alu) begin
            check({tag, ".aluop"}, 64'(IDAluOp),  64'(e.op));
            check({tag, ".in0"},   64'(IDAluIn0), 64'(e.in0));
        end
        if (e.c_in1) check({tag, ".in1"}, 64'(IDAluIn1),    64'(e.in1));
        if (e.c_dst) check({tag, ".dst"}, 64'(IDDst),       64'(e.dst));
        if (e.c_wd)  check({tag, ".wd"},  64'(IDMemWrData), 64'(e.wd));
    endtask

    task automatic idle();
        Stall = 1'b0; Flush = 1'b0; IFEn = 1'b0;
        ExDst = '0; ExWE_ = 1'b1; ExLoad = 1'b0; ExFwd = '0;
        MemDst = '0; MemWE_ = 1'b1; MemFwd = '0;
    endtask

    task automatic put(input logic [29:0] pc, input logic [31:0] insn,
                       input logic [31:0] d0, input logic [31:0] d1);
        idle();
        IFPC = pc; IFInsn = insn; IFEn = 1'b1;
        GprRdData0 = d0; GprRdData1 = d1;
    endtask

    task automatic comb(input string tag, input logic taken, input logic [29:0] addr, input logic haz);
        #1;
        check({tag, ".brtaken"},  64'(BrTaken),  64'(taken));
        check({tag, ".ldhazard"}, 64'(LdHazard), 64'(haz));
        if (taken) check({tag, ".braddr"}, 64'(BrAddr), 64'(addr));
    endtask

    task automatic step(input string tag, input id_exp_t e);
        id_exp_t got;
        sb.push_back(e);
        cur = e;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        compare_reg(tag, got);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        id_exp_t e;
        reset_ = 1'b0;
        idle();
        IFPC = '0; IFInsn = '0; GprRdData0 = '0; GprRdData1 = '0;
        #12;
        compare_reg("reset", e_rst());
        comb("reset", 1'b0, '0, 1'b0);
        @(negedge clk);
        reset_ = 1'b1;
        @(posedge clk);
        #1;

        // ALU immediate / register forms and immediate extension
        put(30'h10, enc_i(6'h03, 5'd1, 5'd2, 16'd5), 32'd10, 32'hDEAD);
        #1;
        check("addui.rdaddr0", 64'(GprRdAddr0), 64'd1);
        check("addui.rdaddr1", 64'(GprRdAddr1), 64'd2);
        comb("addui", 1'b0, '0, 1'b0);
        step("addui", e_alu(30'h10, ALU_ADDU, 32'd10, 32'd5, 5'd2, 1'b0, 2'b00));

        put(30'h11, enc_i(6'h01, 5'd1, 5'd6, 16'hFFFD), 32'd100, 32'd0);
        comb("addsi", 1'b0, '0, 1'b0);
        step("addsi", e_alu(30'h11, ALU_ADDS, 32'd100, 32'hFFFF_FFFD, 5'd6, 1'b0, 2'b00));

        put(30'h12, enc_i(6'h07, 5'd1, 5'd7, 16'h8001), 32'h5, 32'd0);
        comb("ori", 1'b0, '0, 1'b0);
        step("ori", e_alu(30'h12, ALU_OR, 32'h5, 32'h0000_8001, 5'd7, 1'b0, 2'b00));

        put(30'h13, enc_r(6'h08, 5'd1, 5'd2, 5'd8), 32'hF0, 32'h0F);
        comb("xor", 1'b0, '0, 1'b0);
        step("xor", e_alu(30'h13, ALU_XOR, 32'hF0, 32'h0F, 5'd8, 1'b0, 2'b00));

        // Branches, including PC wrap and signed/unsigned compare
        put(30'h100, enc_i(6'h10, 5'd1, 5'd2, 16'hFFFE), 32'd7, 32'd7);
        comb("be_eq", 1'b1, 30'h0FF, 1'b0);
        step("be_eq", e_ctl(30'h100, 1'b1, 2'b00, 3'd0));

        put(30'h100, enc_i(6'h10, 5'd1, 5'd2, 16'hFFFE), 32'd7, 32'd8);
        comb("be_ne", 1'b0, '0, 1'b0);
        step("be_ne", e_ctl(30'h100, 1'b1, 2'b00, 3'd0));

        put(30'h3FFF_FFFF, enc_i(6'h11, 5'd1, 5'd2, 16'd5), 32'd1, 32'd2);
        comb("bne_wrap", 1'b1, 30'h5, 1'b0);
        step("bne_wrap", e_ctl(30'h3FFF_FFFF, 1'b1, 2'b00, 3'd0));

        put(30'h200, enc_i(6'h12, 5'd1, 5'd2, 16'h10), 32'hFFFF_FFFF, 32'd1);
        comb("bsgt", 1'b0, '0, 1'b0);
        step("bsgt", e_ctl(30'h200, 1'b1, 2'b00, 3'd0));

        put(30'h200, enc_i(6'h13, 5'd1, 5'd2, 16'h10), 32'hFFFF_FFFF, 32'd1);
        comb("bugt", 1'b1, 30'h211, 1'b0);
        step("bugt", e_ctl(30'h200, 1'b1, 2'b00, 3'd0));

        put(30'h40, enc_i(6'h14, 5'd3, 5'd0, 16'd0), 32'h1234, 32'd0);
        comb("jmp", 1'b1, 30'h48D, 1'b0);
        step("jmp", e_ctl(30'h40, 1'b1, 2'b00, 3'd0));

        put(30'h20, enc_i(6'h15, 5'd3, 5'd0, 16'd0), 32'h1234, 32'd0);
        comb("call", 1'b1, 30'h48D, 1'b0);
        e = e_alu(30'h20, ALU_PASS, 32'h84, 32'd0, 5'd31, 1'b0, 2'b00);
        e.c_in1 = 0;
        step("call", e);

        // Memory ops
        put(30'h30, enc_i(6'h16, 5'd1, 5'd4, 16'hFFFC), 32'h1000, 32'd0);
        comb("ldw", 1'b0, '0, 1'b0);
        step("ldw", e_alu(30'h30, ALU_ADDU, 32'h1000, 32'hFFFF_FFFC, 5'd4, 1'b0, 2'b01));

        put(30'h31, enc_i(6'h17, 5'd1, 5'd5, 16'd8), 32'h2000, 32'hCAFE_F00D);
        comb("stw", 1'b0, '0, 1'b0);
        e = e_alu(30'h31, ALU_ADDU, 32'h2000, 32'd8, 5'd0, 1'b1, 2'b10);
        e.c_dst = 0; e.wd = 32'hCAFE_F00D; e.c_wd = 1;
        step("stw", e);

        // Bypass / producer hazards
        put(30'h50, enc_r(6'h02, 5'd3, 5'd1, 5'd6), 32'h11, 32'h22);
        ExDst = 5'd3; ExWE_ = 1'b0; ExFwd = 32'h55;
        MemDst = 5'd3; MemWE_ = 1'b0; MemFwd = 32'h66;
`ifdef ID_FORWARD_EN
        comb("fwd_ex", 1'b0, '0, 1'b0);
        step("fwd_ex", e_alu(30'h50, ALU_ADDU, 32'h55, 32'h22, 5'd6, 1'b0, 2'b00));
`else
        comb("fwd_ex", 1'b0, '0, 1'b1);
        step("fwd_ex", e_bub());
`endif

        put(30'h51, enc_r(6'h02, 5'd3, 5'd1, 5'd6), 32'h11, 32'h22);
        ExDst = 5'd3;
        MemDst = 5'd1; MemWE_ = 1'b0; MemFwd = 32'h77;
`ifdef ID_FORWARD_EN
        comb("fwd_mem", 1'b0, '0, 1'b0);
        step("fwd_mem", e_alu(30'h51, ALU_ADDU, 32'h11, 32'h77, 5'd6, 1'b0, 2'b00));
`else
        comb("fwd_mem", 1'b0, '0, 1'b1);
        step("fwd_mem", e_bub());
`endif

        put(30'h52, enc_r(6'h02, 5'd3, 5'd1, 5'd6), 32'h11, 32'h22);
        ExDst = 5'd3; ExFwd = 32'h55; MemDst = 5'd1; MemFwd = 32'h77;
        comb("no_we", 1'b0, '0, 1'b0);
        step("no_we", e_alu(30'h52, ALU_ADDU, 32'h11, 32'h22, 5'd6, 1'b0, 2'b00));

        put(30'h53, enc_r(6'h02, 5'd4, 5'd1, 5'd5), 32'h1, 32'h2);
        ExDst = 5'd4; ExWE_ = 1'b0; ExLoad = 1'b1;
        comb("ld_use", 1'b0, '0, 1'b1);
        step("ld_use", e_bub());

        put(30'h54, enc_i(6'h10, 5'd4, 5'd4, 16'd3), 32'd7, 32'd7);
        ExDst = 5'd4; ExWE_ = 1'b0; ExLoad = 1'b1;
        comb("ld_use_br", 1'b0, '0, 1'b1);
        step("ld_use_br", e_bub());

        put(30'h55, enc_i(6'h03, 5'd1, 5'd9, 16'd7), 32'd3, 32'd0);
        ExDst = 5'd9; ExWE_ = 1'b0; ExLoad = 1'b1;
        comb("ld_dst_only", 1'b0, '0, 1'b0);
        step("ld_dst_only", e_alu(30'h55, ALU_ADDU, 32'd3, 32'd7, 5'd9, 1'b0, 2'b00));

        // Stall / flush interaction
        put(30'h58, enc_i(6'h03, 5'd1, 5'd2, 16'd5), 32'd1, 32'd0);
        comb("pre_stall", 1'b0, '0, 1'b0);
        step("pre_stall", e_alu(30'h58, ALU_ADDU, 32'd1, 32'd5, 5'd2, 1'b0, 2'b00));

        put(30'h60, enc_i(6'h01, 5'd1, 5'd3, 16'd1), 32'd9, 32'd0);
        Stall = 1'b1;
        comb("stall", 1'b0, '0, 1'b0);
        step("stall", cur);

        put(30'h61, enc_i(6'h01, 5'd1, 5'd3, 16'd1), 32'd9, 32'd0);
        Stall = 1'b1; Flush = 1'b1;
        comb("stall_flush", 1'b0, '0, 1'b0);
        step("stall_flush", e_bub());

        put(30'h62, enc_i(6'h03, 5'd1, 5'd2, 16'd5), 32'd2, 32'd0);
        comb("reload", 1'b0, '0, 1'b0);
        step("reload", e_alu(30'h62, ALU_ADDU, 32'd2, 32'd5, 5'd2, 1'b0, 2'b00));

        put(30'h63, enc_i(6'h03, 5'd1, 5'd2, 16'd5), 32'd2, 32'd0);
        Flush = 1'b1;
        comb("flush", 1'b0, '0, 1'b0);
        step("flush", e_bub());

        // Exceptions and invalid fetch
        put(30'h64, enc_i(6'h3F, 5'd1, 5'd2, 16'd0), 32'd0, 32'd0);
        comb("illegal", 1'b0, '0, 1'b0);
        step("illegal", e_ctl(30'h64, 1'b1, 2'b00, 3'd1));

        put(30'h65, enc_i(6'h18, 5'd0, 5'd0, 16'd0), 32'd0, 32'd0);
        comb("trap", 1'b0, '0, 1'b0);
        step("trap", e_ctl(30'h65, 1'b1, 2'b00, 3'd2));

        put(30'h66, enc_i(6'h10, 5'd1, 5'd2, 16'd4), 32'd7, 32'd7);
        IFEn = 1'b0;
        comb("if_invalid", 1'b0, '0, 1'b0);
        step("if_invalid", e_bub());

        // Asynchronous reset in the middle of a cycle
        put(30'h70, enc_i(6'h03, 5'd1, 5'd2, 16'd5), 32'd4, 32'd0);
        comb("pre_rst", 1'b0, '0, 1'b0);
        step("pre_rst", e_alu(30'h70, ALU_ADDU, 32'd4, 32'd5, 5'd2, 1'b0, 2'b00));
        #2;
        reset_ = 1'b0;
        #1;
        compare_reg("async_rst", e_rst());
        #2;
        reset_ = 1'b1;

        put(30'h71, enc_i(6'h03, 5'd1, 5'd2, 16'd6), 32'd8, 32'd0);
        comb("post_rst", 1'b0, '0, 1'b0);
        step("post_rst", e_alu(30'h71, ALU_ADDU, 32'd8, 32'd6, 5'd2, 1'b0, 2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
